// File: rtl/tpu_pkg.sv
// Shared types and header field positions for the TPU command sequencer.
package tpu_pkg;

  localparam int unsigned HDR_W      = 8;
  localparam int unsigned OP_MSB     = 7;
  localparam int unsigned OP_LSB     = 6;
  localparam int unsigned RSV_MSB    = 5;
  localparam int unsigned RSV_LSB    = 2;
  localparam int unsigned CNT_MSB    = 1;
  localparam int unsigned CNT_LSB    = 0;
  localparam int unsigned N_STROBE   = 4;
  localparam int unsigned LOAD_BYTES = 4;

  // Opcode value doubles as the strobe index: write, accu, clear, read.
  typedef enum logic [1:0] {
    OP_LOAD  = 2'd0,
    OP_ACCUM = 2'd1,
    OP_CLEAR = 2'd2,
    OP_READ  = 2'd3
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_LOAD_GET = 3'd1,
    ST_STROBE   = 3'd2,
    ST_GAP      = 3'd3,
    ST_SETTLE   = 3'd4,
    ST_DONE     = 3'd5
  } state_e;

  function automatic op_e hdr_op(input logic [HDR_W-1:0] hdr);
    return op_e'(hdr[OP_MSB:OP_LSB]);
  endfunction

  function automatic logic hdr_rsv_bad(input logic [HDR_W-1:0] hdr);
    return |hdr[RSV_MSB:RSV_LSB];
  endfunction

endpackage

// File: rtl/strobe_gap_timer.sv
// One-cycle strobe generator plus a loadable down-counter that times the
// post-pulse gap and the LOAD settle window.
module strobe_gap_timer #(
  parameter int unsigned CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             fire_i,
  input  logic [1:0]       sel_i,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  output logic [3:0]       strobe_o,
  output logic             expired_c
);

  logic [3:0]       strobe_q, strobe_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Strobe is high for exactly the cycle after fire_i; counter saturates at 0.
  always_comb begin
    strobe_d = '0;
    cnt_d    = cnt_q;
    if (fire_i) begin
      strobe_d = 4'(4'b0001 << sel_i);
    end
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      strobe_q <= '0;
      cnt_q    <= '0;
    end else begin
      strobe_q <= strobe_d;
      cnt_q    <= cnt_d;
    end
  end

  assign strobe_o  = strobe_q;
  assign expired_c = (cnt_q == '0);

endmodule

// File: rtl/tpu_cmd_sequencer.sv
// Converts a byte command stream into the TPU core's strobe/data pin protocol,
// spacing every strobe by PULSE_GAP idle cycles.
module tpu_cmd_sequencer
  import tpu_pkg::*;
#(
  parameter int unsigned PULSE_GAP   = 3,
  parameter int unsigned LOAD_SETTLE = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [7:0] tpu_data,
  output logic       tpu_write,
  output logic       tpu_accu,
  output logic       tpu_clear,
  output logic       tpu_read,
  output logic       busy,
  output logic       cmd_done,
  output logic       cmd_err
);

  localparam int unsigned MAX_CNT = (PULSE_GAP > LOAD_SETTLE) ? PULSE_GAP : LOAD_SETTLE;
  localparam int unsigned CNT_W   = (MAX_CNT > 2) ? $clog2(MAX_CNT) : 1;
  // Counter runs N-1..0, giving N cycles in the timed state (minimum 1).
  localparam logic [CNT_W-1:0] GAP_LOAD    = CNT_W'((PULSE_GAP > 0) ? PULSE_GAP - 1 : 0);
  localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'((LOAD_SETTLE > 0) ? LOAD_SETTLE - 1 : 0);

  state_e           state_q, state_d;
  op_e              op_q, op_d;
  logic [1:0]       byte_cnt_q, byte_cnt_d;
  logic [1:0]       rd_cnt_q, rd_cnt_d;
  logic [7:0]       data_q, data_d;
  logic             in_ready_q, in_ready_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             err_q, err_d;

  logic             hs_c;
  logic             fire_c;
  logic             tmr_load_c;
  logic [CNT_W-1:0] tmr_val_c;
  logic             tmr_expired_c;
  logic [3:0]       strobe_w;

  assign hs_c = in_valid & in_ready_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      op_q       <= OP_LOAD;
      byte_cnt_q <= '0;
      rd_cnt_q   <= '0;
      data_q     <= '0;
      in_ready_q <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      byte_cnt_q <= byte_cnt_d;
      rd_cnt_q   <= rd_cnt_d;
      data_q     <= data_d;
      in_ready_q <= in_ready_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    byte_cnt_d = byte_cnt_q;
    rd_cnt_d   = rd_cnt_q;
    data_d     = data_q;
    done_d     = 1'b0;
    err_d      = 1'b0;
    fire_c     = 1'b0;
    tmr_load_c = 1'b0;
    tmr_val_c  = GAP_LOAD;

    unique case (state_q)
      ST_IDLE: begin
        if (hs_c) begin
          if (hdr_rsv_bad(in_data)) begin
            err_d = 1'b1;
          end else begin
            op_d = hdr_op(in_data);
            if (op_d == OP_LOAD) begin
              state_d    = ST_LOAD_GET;
              byte_cnt_d = '0;
            end else begin
              state_d = ST_STROBE;
              fire_c  = 1'b1;
              if (op_d == OP_READ) begin
                rd_cnt_d = in_data[CNT_MSB:CNT_LSB];
              end
            end
          end
        end
      end

      ST_LOAD_GET: begin
        if (hs_c) begin
          data_d  = in_data;
          state_d = ST_STROBE;
          fire_c  = 1'b1;
        end
      end

      ST_STROBE: begin
        state_d    = ST_GAP;
        tmr_load_c = 1'b1;
        tmr_val_c  = GAP_LOAD;
      end

      // Gap exit decides between next payload byte, next read pulse, settle or done.
      ST_GAP: begin
        if (tmr_expired_c) begin
          if (op_q == OP_LOAD) begin
            if (byte_cnt_q != 2'(LOAD_BYTES - 1)) begin
              byte_cnt_d = byte_cnt_q + 2'd1;
              state_d    = ST_LOAD_GET;
            end else begin
              state_d    = ST_SETTLE;
              tmr_load_c = 1'b1;
              tmr_val_c  = SETTLE_LOAD;
            end
          end else if ((op_q == OP_READ) && (rd_cnt_q != 2'd0)) begin
            rd_cnt_d = rd_cnt_q - 2'd1;
            state_d  = ST_STROBE;
            fire_c   = 1'b1;
          end else begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end
        end
      end

      ST_SETTLE: begin
        if (tmr_expired_c) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    in_ready_d = (state_d == ST_IDLE) || (state_d == ST_LOAD_GET);
    busy_d     = (state_d != ST_IDLE);
  end

  strobe_gap_timer #(
    .CNT_W (CNT_W)
  ) u_timer (
    .clk        (clk),
    .rst        (rst),
    .fire_i     (fire_c),
    .sel_i      (op_d),
    .load_i     (tmr_load_c),
    .load_val_i (tmr_val_c),
    .strobe_o   (strobe_w),
    .expired_c  (tmr_expired_c)
  );

  assign in_ready  = in_ready_q;
  assign tpu_data  = data_q;
  assign tpu_write = strobe_w[0];
  assign tpu_accu  = strobe_w[1];
  assign tpu_clear = strobe_w[2];
  assign tpu_read  = strobe_w[3];
  assign busy      = busy_q;
  assign cmd_done  = done_q;
  assign cmd_err   = err_q;

endmodule

// File: tb/tb_tpu_cmd_sequencer.sv
// Bench for tpu_cmd_sequencer: directed scenarios plus random command streams,
// checked against an event-timeline model built from the command rules.
module tb_tpu_cmd_sequencer;

  localparam int unsigned PG = 3;
  localparam int unsigned LS = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] tpu_data;
  logic       tpu_write, tpu_accu, tpu_clear, tpu_read;
  logic       busy, cmd_done, cmd_err;

  tpu_cmd_sequencer #(
    .PULSE_GAP   (PG),
    .LOAD_SETTLE (LS)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .tpu_data  (tpu_data),
    .tpu_write (tpu_write),
    .tpu_accu  (tpu_accu),
    .tpu_clear (tpu_clear),
    .tpu_read  (tpu_read),
    .busy      (busy),
    .cmd_done  (cmd_done),
    .cmd_err   (cmd_err)
  );

  always #5 clk = ~clk;

  // Event kinds: 0 write, 1 accu, 2 clear, 3 read, 4 done, 5 err.
  typedef struct packed {
    logic [31:0] cyc;
    logic [3:0]  kind;
    logic [7:0]  data;
  } ev_t;

  int unsigned cyc = 0;
  int          viol = 0;
  int          checks = 0;
  int          failures = 0;
  int unsigned ready_from = 0;
  ev_t         obs_q[$];
  ev_t         exp_q[$];
  int          obs_idx = 0;
  int          exp_idx = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    logic [5:0] v;
    v = {cmd_err, cmd_done, tpu_read, tpu_clear, tpu_accu, tpu_write};
    if ($countones(v) > 1) viol = viol + 1;
    for (int k = 0; k < 6; k++) begin
      if (v[k]) obs_q.push_back({32'(cyc), 4'(k), (k == 0) ? tpu_data : 8'h00});
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic void push(input int unsigned c, input int k, input logic [7:0] d);
    exp_q.push_back({32'(c), 4'(k), d});
  endfunction

  // Presents one byte; the handshake edge must match the model's ready time.
  task automatic send(input logic [7:0] b, input int stall, output int unsigned e);
    int unsigned exp_e;
    bit          got;
    in_valid = 1'b0;
    repeat (stall) @(negedge clk);
    in_data  = b;
    in_valid = 1'b1;
    exp_e = (ready_from > cyc + 1) ? ready_from : cyc + 1;
    got = 1'b0;
    e = cyc;
    for (int t = 0; t < 400 && !got; t++) begin
      if (in_ready) begin
        @(posedge clk);
        #1;
        e = cyc;
        got = 1'b1;
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    chk("handshake_edge", got ? 64'(e) : 64'hFFFF_FFFF, 64'(exp_e));
  endtask

  task automatic run_cmd(input logic [7:0] hdr, input logic [31:0] pay, input int stall);
    int unsigned e, d;
    int          op, n;
    logic [7:0]  b;
    send(hdr, stall, e);
    op = int'(hdr[7:6]);
    n  = int'(hdr[1:0]);
    if (hdr[5:2] != 4'd0) begin
      push(e, 5, 8'h00);
      ready_from = e + 1;
    end else if (op == 0) begin
      ready_from = e + 1;
      for (int j = 0; j < 4; j++) begin
        b = pay[8*j +: 8];
        send(b, stall, e);
        push(e, 0, b);
        ready_from = e + PG + 2;
      end
      d = e + PG + LS + 1;
      push(d, 4, 8'h00);
      ready_from = d + 2;
    end else if (op == 3) begin
      for (int i = 0; i <= n; i++) push(e + i * (PG + 1), 3, 8'h00);
      d = e + (n + 1) * (PG + 1);
      push(d, 4, 8'h00);
      ready_from = d + 2;
    end else begin
      push(e, op, 8'h00);
      d = e + PG + 1;
      push(d, 4, 8'h00);
      ready_from = d + 2;
    end
  endtask

  task automatic wait_idle();
    for (int t = 0; t < 2000 && cyc < ready_from; t++) @(negedge clk);
    chk("idle_reached", 64'(cyc >= ready_from), 64'd1);
    repeat (2) @(negedge clk);
  endtask

  task automatic compare_events(input string tag);
    chk({tag, "_count"}, 64'(obs_q.size() - obs_idx), 64'(exp_q.size() - exp_idx));
    while (exp_idx < exp_q.size() && obs_idx < obs_q.size()) begin
      chk(tag, 64'(obs_q[obs_idx]), 64'(exp_q[exp_idx]));
      obs_idx++;
      exp_idx++;
    end
    obs_idx = obs_q.size();
    exp_idx = exp_q.size();
  endtask

  initial begin
    int unsigned e;
    logic [7:0]  hdr;
    logic [7:0]  stall_bytes[4];

    // Reset state
    repeat (3) @(negedge clk);
    chk("reset_outputs", 64'({tpu_write, tpu_accu, tpu_clear, tpu_read, busy, cmd_done, cmd_err}), 64'd0);
    chk("reset_tpu_data", 64'(tpu_data), 64'h00);
    rst = 1'b1;
    ready_from = 0;
    @(negedge clk);
    chk("in_ready_after_reset", 64'(in_ready), 64'd1);

    // LOAD with four payload bytes, valid held high
    run_cmd(8'h00, 32'h7856_3412, 0);
    wait_idle();
    compare_events("load");
    chk("tpu_data_hold_after_load", 64'(tpu_data), 64'h78);

    // READ with count 2
    run_cmd(8'hC1, 32'h0, 0);
    wait_idle();
    compare_events("read");

    // ACCUM then CLEAR, in_ready low while the ACCUM is in flight
    run_cmd(8'h40, 32'h0, 0);
    for (int k = 0; k <= int'(PG) + 1; k++) begin
      chk("accum_in_ready_low", 64'(in_ready), 64'd0);
      chk("accum_busy_high", 64'(busy), 64'd1);
      @(negedge clk);
    end
    chk("accum_back_to_idle_ready", 64'(in_ready), 64'd1);
    chk("accum_back_to_idle_busy", 64'(busy), 64'd0);
    run_cmd(8'h80, 32'h0, 0);
    wait_idle();
    compare_events("accum_clear");
    chk("tpu_data_hold_after_strobes", 64'(tpu_data), 64'h78);

    // Reserved bits set: error pulse only, then a normal ACCUM
    run_cmd(8'h44, 32'h0, 0);
    chk("rsv_busy_low", 64'(busy), 64'd0);
    chk("rsv_in_ready", 64'(in_ready), 64'd1);
    run_cmd(8'h40, 32'h0, 0);
    wait_idle();
    compare_events("reserved");

    // Reset after the second payload byte of a LOAD
    send(8'h00, 0, e);
    ready_from = e + 1;
    send(8'hA1, 0, e);
    push(e, 0, 8'hA1);
    ready_from = e + PG + 2;
    send(8'hB2, 0, e);
    push(e, 0, 8'hB2);
    #2;
    rst = 1'b0;
    #1;
    chk("midreset_outputs", 64'({tpu_write, tpu_accu, tpu_clear, tpu_read, busy, cmd_done, cmd_err}), 64'd0);
    chk("midreset_tpu_data", 64'(tpu_data), 64'h00);
    repeat (3) @(negedge clk);
    compare_events("reset_abort");
    rst = 1'b1;
    ready_from = 0;
    #1;
    chk("in_ready_after_midreset", 64'(in_ready), 64'd1);
    @(negedge clk);
    chk("in_ready_first_cycle", 64'(in_ready), 64'd1);
    run_cmd(8'h00, 32'hDDCC_BBAA, 0);
    wait_idle();
    compare_events("load_after_reset");

    // 20-cycle in_valid stall between payload bytes
    stall_bytes = '{8'h11, 8'h22, 8'h33, 8'h44};
    send(8'h00, 0, e);
    ready_from = e + 1;
    for (int j = 0; j < 4; j++) begin
      send(stall_bytes[j], 0, e);
      push(e, 0, stall_bytes[j]);
      ready_from = e + PG + 2;
      if (j == 1) begin
        repeat (PG + 1) @(negedge clk);
        for (int k = 0; k < 20; k++) begin
          chk("stall_busy", 64'(busy), 64'd1);
          chk("stall_in_ready", 64'(in_ready), 64'd1);
          @(negedge clk);
        end
      end
    end
    push(e + PG + LS + 1, 4, 8'h00);
    ready_from = e + PG + LS + 3;
    wait_idle();
    compare_events("stall");

    // Random back-to-back command stream
    for (int i = 0; i < 40; i++) begin
      hdr = 8'($urandom);
      if ($urandom_range(0, 4) != 0) hdr[5:2] = 4'd0;
      run_cmd(hdr, $urandom, int'($urandom_range(0, 2)));
    end
    wait_idle();
    compare_events("random");

    chk("exclusive_outputs", 64'(viol), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
